// File: rtl/rv_pkg.sv
// Shared RV32I definitions: opcodes, register index width and per-opcode operand usage.
package rv_pkg;

   localparam int unsigned REG_IDX_WIDTH = 5;
   localparam int unsigned NUM_REGS      = 32;
   localparam int unsigned OPC_WIDTH     = 7;

   localparam logic [OPC_WIDTH-1:0] OPC_OP     = 7'b0110011;
   localparam logic [OPC_WIDTH-1:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [OPC_WIDTH-1:0] OPC_LOAD   = 7'b0000011;
   localparam logic [OPC_WIDTH-1:0] OPC_JALR   = 7'b1100111;
   localparam logic [OPC_WIDTH-1:0] OPC_STORE  = 7'b0100011;
   localparam logic [OPC_WIDTH-1:0] OPC_BRANCH = 7'b1100011;
   localparam logic [OPC_WIDTH-1:0] OPC_LUI    = 7'b0110111;
   localparam logic [OPC_WIDTH-1:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [OPC_WIDTH-1:0] OPC_JAL    = 7'b1101111;

   function automatic logic uses_rs1(input logic [OPC_WIDTH-1:0] opc);
      case (opc)
         OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_STORE, OPC_BRANCH: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic uses_rs2(input logic [OPC_WIDTH-1:0] opc);
      case (opc)
         OPC_OP, OPC_STORE, OPC_BRANCH: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic writes_rd(input logic [OPC_WIDTH-1:0] opc);
      case (opc)
         OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_JAL: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/rv_scoreboard.sv
// One busy bit per architectural register; a set and clear of the same register in one cycle leaves it set.
module rv_scoreboard
   import rv_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     set_en,
   input  logic [REG_IDX_WIDTH-1:0] set_idx,
   input  logic                     clr_en,
   input  logic [REG_IDX_WIDTH-1:0] clr_idx,
   output logic [NUM_REGS-1:0]      busy
);

   logic [NUM_REGS-1:0] busy_next;

   // Clear first so a same-register set overrides it; x0 is forced idle.
   always_comb begin
      busy_next = busy;
      if (clr_en) busy_next[clr_idx] = 1'b0;
      if (set_en) busy_next[set_idx] = 1'b1;
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) busy <= '0;
      else       busy <= busy_next;
   end

endmodule

// File: rtl/operand_fetch.sv
// Issue stage: scoreboard hazard check, writeback forwarding and the execute payload register.
module operand_fetch
   import rv_pkg::*;
#(
   parameter int unsigned REG_DATA_WIDTH = 32,
   parameter int unsigned INST_WIDTH     = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      inst_valid,
   output logic                      inst_ready,
   input  logic [INST_WIDTH-1:0]     inst,
   output logic [REG_IDX_WIDTH-1:0]  read_reg_0,
   output logic [REG_IDX_WIDTH-1:0]  read_reg_1,
   input  logic [REG_DATA_WIDTH-1:0] dout_reg_0,
   input  logic [REG_DATA_WIDTH-1:0] dout_reg_1,
   input  logic                      wb_enable,
   input  logic [REG_IDX_WIDTH-1:0]  wb_reg,
   input  logic [REG_DATA_WIDTH-1:0] wb_data,
   output logic                      ex_valid,
   input  logic                      ex_ready,
   output logic [INST_WIDTH-1:0]     ex_inst,
   output logic [REG_DATA_WIDTH-1:0] ex_rs1_data,
   output logic [REG_DATA_WIDTH-1:0] ex_rs2_data
);

   logic [OPC_WIDTH-1:0]      opcode;
   logic [REG_IDX_WIDTH-1:0]  rs1_idx, rs2_idx, rd_idx;
   logic                      need_rs1, need_rs2, need_rd;
   logic                      wb_hit_rs1, wb_hit_rs2, wb_hit_rd;
   logic                      hazard, fire;
   logic [NUM_REGS-1:0]       busy;
   logic [REG_DATA_WIDTH-1:0] fwd_rs1, fwd_rs2;

   assign opcode  = inst[6:0];
   assign rs1_idx = inst[19:15];
   assign rs2_idx = inst[24:20];
   assign rd_idx  = inst[11:7];

   assign read_reg_0 = rs1_idx;
   assign read_reg_1 = rs2_idx;

   assign need_rs1 = uses_rs1(opcode);
   assign need_rs2 = uses_rs2(opcode);
   assign need_rd  = writes_rd(opcode);

   assign wb_hit_rs1 = wb_enable && (wb_reg == rs1_idx) && (rs1_idx != '0);
   assign wb_hit_rs2 = wb_enable && (wb_reg == rs2_idx) && (rs2_idx != '0);
   assign wb_hit_rd  = wb_enable && (wb_reg == rd_idx)  && (rd_idx  != '0);

   // busy[0] is tied low, so x0 operands and destinations never stall.
   assign hazard = (need_rs1 && busy[rs1_idx] && !wb_hit_rs1)
                 | (need_rs2 && busy[rs2_idx] && !wb_hit_rs2)
                 | (need_rd  && busy[rd_idx]  && !wb_hit_rd);

   assign inst_ready = !reset && !hazard && (!ex_valid || ex_ready);
   assign fire       = inst_valid && inst_ready;

   assign fwd_rs1 = (rs1_idx == '0) ? '0 : (wb_hit_rs1 ? wb_data : dout_reg_0);
   assign fwd_rs2 = (rs2_idx == '0) ? '0 : (wb_hit_rs2 ? wb_data : dout_reg_1);

   rv_scoreboard u_scoreboard (
      .clk     (clk),
      .reset   (reset),
      .set_en  (fire && need_rd),
      .set_idx (rd_idx),
      .clr_en  (wb_enable),
      .clr_idx (wb_reg),
      .busy    (busy)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_valid    <= 1'b0;
         ex_inst     <= '0;
         ex_rs1_data <= '0;
         ex_rs2_data <= '0;
      end else if (fire) begin
         ex_valid    <= 1'b1;
         ex_inst     <= inst;
         ex_rs1_data <= fwd_rs1;
         ex_rs2_data <= fwd_rs2;
      end else if (ex_ready) begin
         ex_valid    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: issue, RAW/WAW stalls, forwarding, backpressure and async reset.
module tb_operand_fetch;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        inst_valid = 1'b0;
   logic        inst_ready;
   logic [31:0] inst = '0;
   logic [4:0]  read_reg_0, read_reg_1;
   logic [31:0] dout_reg_0 = '0, dout_reg_1 = '0;
   logic        wb_enable = 1'b0;
   logic [4:0]  wb_reg = '0;
   logic [31:0] wb_data = '0;
   logic        ex_valid;
   logic        ex_ready = 1'b1;
   logic [31:0] ex_inst, ex_rs1_data, ex_rs2_data;

   int total = 0;
   int bad   = 0;

   operand_fetch dut (
      .clk         (clk),
      .reset       (reset),
      .inst_valid  (inst_valid),
      .inst_ready  (inst_ready),
      .inst        (inst),
      .read_reg_0  (read_reg_0),
      .read_reg_1  (read_reg_1),
      .dout_reg_0  (dout_reg_0),
      .dout_reg_1  (dout_reg_1),
      .wb_enable   (wb_enable),
      .wb_reg      (wb_reg),
      .wb_data     (wb_data),
      .ex_valid    (ex_valid),
      .ex_ready    (ex_ready),
      .ex_inst     (ex_inst),
      .ex_rs1_data (ex_rs1_data),
      .ex_rs2_data (ex_rs2_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state
      #1 reset = 1'b1;
      #1;
      chk("rst_ex_valid", 32'(ex_valid), 32'd0);
      chk("rst_ex_inst", ex_inst, 32'd0);
      chk("rst_rs1", ex_rs1_data, 32'd0);
      chk("rst_rs2", ex_rs2_data, 32'd0);
      chk("rst_busy", dut.u_scoreboard.busy, 32'd0);
      chk("rst_ready", 32'(inst_ready), 32'd0);
      tick;
      tick;
      reset = 1'b0;

      // 1: ADD x3,x1,x2
      inst = 32'h002081B3; inst_valid = 1'b1;
      dout_reg_0 = 32'h11; dout_reg_1 = 32'h22;
      #1;
      chk("t1_rr0", 32'(read_reg_0), 32'd1);
      chk("t1_rr1", 32'(read_reg_1), 32'd2);
      chk("t1_ready", 32'(inst_ready), 32'd1);
      tick;
      chk("t1_ex_valid", 32'(ex_valid), 32'd1);
      chk("t1_ex_inst", ex_inst, 32'h002081B3);
      chk("t1_rs1", ex_rs1_data, 32'h11);
      chk("t1_rs2", ex_rs2_data, 32'h22);
      chk("t1_busy", dut.u_scoreboard.busy, 32'h0000_0008);

      // 2: ADDI x4,x3,1 stalls on x3 until writeback, then forwards wb_data
      inst = 32'h00118213; dout_reg_0 = 32'h99;
      #1;
      chk("t2_stall_ready", 32'(inst_ready), 32'd0);
      tick;
      chk("t2_bubble_valid", 32'(ex_valid), 32'd0);
      chk("t2_busy_hold", dut.u_scoreboard.busy, 32'h0000_0008);
      wb_enable = 1'b1; wb_reg = 5'd3; wb_data = 32'h33;
      #1;
      chk("t2_wb_ready", 32'(inst_ready), 32'd1);
      tick;
      wb_enable = 1'b0;
      chk("t2_ex_valid", 32'(ex_valid), 32'd1);
      chk("t2_ex_inst", ex_inst, 32'h00118213);
      chk("t2_rs1_fwd", ex_rs1_data, 32'h33);
      chk("t2_busy", dut.u_scoreboard.busy, 32'h0000_0010);

      // 3: x0 destination / sources
      inst = 32'h00500013; dout_reg_0 = 32'hAA; dout_reg_1 = 32'hBB;
      #1;
      chk("t3a_ready", 32'(inst_ready), 32'd1);
      tick;
      chk("t3a_ex_inst", ex_inst, 32'h00500013);
      chk("t3a_rs1_zero", ex_rs1_data, 32'd0);
      chk("t3a_busy", dut.u_scoreboard.busy, 32'h0000_0010);
      inst = 32'h000000B3;
      #1;
      chk("t3b_ready", 32'(inst_ready), 32'd1);
      tick;
      chk("t3b_ex_valid", 32'(ex_valid), 32'd1);
      chk("t3b_ex_inst", ex_inst, 32'h000000B3);
      chk("t3b_rs1_zero", ex_rs1_data, 32'd0);
      chk("t3b_rs2_zero", ex_rs2_data, 32'd0);
      chk("t3b_busy", dut.u_scoreboard.busy, 32'h0000_0012);

      // 4: backpressure holds payload; LUI x7 waits
      inst = 32'h123453B7; ex_ready = 1'b0;
      dout_reg_0 = 32'h5A5A; dout_reg_1 = 32'hA5A5;
      #1;
      chk("t4_ready_bp", 32'(inst_ready), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("t4_hold_valid", 32'(ex_valid), 32'd1);
         chk("t4_hold_inst", ex_inst, 32'h000000B3);
         chk("t4_hold_rs1", ex_rs1_data, 32'd0);
         chk("t4_hold_rs2", ex_rs2_data, 32'd0);
         chk("t4_hold_busy", dut.u_scoreboard.busy, 32'h0000_0012);
         chk("t4_hold_ready", 32'(inst_ready), 32'd0);
      end
      ex_ready = 1'b1;
      #1;
      chk("t4_release_ready", 32'(inst_ready), 32'd1);
      tick;
      chk("t4_ex_inst", ex_inst, 32'h123453B7);
      chk("t4_busy", dut.u_scoreboard.busy, 32'h0000_0092);

      // 5: WAW on x5; set wins over same-cycle clear
      inst = 32'h00100293;
      #1;
      chk("t5a_ready", 32'(inst_ready), 32'd1);
      tick;
      chk("t5a_ex_inst", ex_inst, 32'h00100293);
      chk("t5a_busy", dut.u_scoreboard.busy, 32'h0000_00B2);
      inst = 32'h00200293;
      #1;
      chk("t5b_stall", 32'(inst_ready), 32'd0);
      tick;
      chk("t5b_bubble", 32'(ex_valid), 32'd0);
      wb_enable = 1'b1; wb_reg = 5'd5; wb_data = 32'h55;
      #1;
      chk("t5b_wb_ready", 32'(inst_ready), 32'd1);
      tick;
      wb_enable = 1'b0;
      chk("t5b_ex_inst", ex_inst, 32'h00200293);
      chk("t5b_busy", dut.u_scoreboard.busy, 32'h0000_00B2);

      // 6: async reset mid-flight; ADDI x3,x0,7 leaves x3 busy first
      inst = 32'h00700193;
      tick;
      inst_valid = 1'b0;
      chk("t6_pre_valid", 32'(ex_valid), 32'd1);
      chk("t6_pre_busy", dut.u_scoreboard.busy, 32'h0000_00BA);
      reset = 1'b1;
      #1;
      chk("t6_async_valid", 32'(ex_valid), 32'd0);
      chk("t6_async_inst", ex_inst, 32'd0);
      chk("t6_async_busy", dut.u_scoreboard.busy, 32'd0);
      #1;
      reset = 1'b0;
      inst = 32'h00118213; inst_valid = 1'b1; dout_reg_0 = 32'h77;
      #1;
      chk("t6_ready", 32'(inst_ready), 32'd1);
      tick;
      inst_valid = 1'b0;
      chk("t6_ex_valid", 32'(ex_valid), 32'd1);
      chk("t6_ex_inst", ex_inst, 32'h00118213);
      chk("t6_rs1", ex_rs1_data, 32'h77);
      chk("t6_busy", dut.u_scoreboard.busy, 32'h0000_0010);
      tick;
      chk("t6_drain_valid", 32'(ex_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
